alu_issuer: RTL
===============

Name: alu_issuer

Overview:
- Command-side master for the registered four-op ALU used in the Doppler processing datapath.
- Accepts one arithmetic request at a time over a valid/ready handshake and drives the ALU operand and opcode inputs.
- Waits a fixed, parameterised ALU latency, then captures the ALU result and returns it over a valid/ready response handshake with the request tag.
- Sits between the Doppler control sequencer, which issues requests, and the ALU instance.

Parameters:
- WIDTH, 32, operand and result width in bits.
- LAT, 1, ALU result latency in clock edges after operands are presented; legal range 1..15.
- TAG_W, 4, width of the request/response tag.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  issuer can accept a request.
- req_op  in  2  opcode: 00 Add, 01 Sub, 10 Mul, 11 Div.
- req_a  in  WIDTH  operand a; subtrahend for Sub, divisor for Div.
- req_b  in  WIDTH  operand b; minuend for Sub, dividend for Div.
- req_tag  in  TAG_W  caller tag, returned unchanged.
- alu_op  out  2  opcode to the ALU.
- alu_a  out  WIDTH  operand a to the ALU.
- alu_b  out  WIDTH  operand b to the ALU.
- alu_result  in  WIDTH  registered ALU result.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  WIDTH  captured result.
- rsp_tag  out  TAG_W  tag of the completed request.
- rsp_err  out  1  error flag; see Optional Feature.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, counter = 0.
  - alu_op/alu_a/alu_b = 0; rsp_valid = 0; rsp_result = 0; rsp_tag = 0; rsp_err = 0.
  - Any in-flight request is discarded.
- req_ready is combinational: 1 only in IDLE. All other outputs are registered.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_valid & req_ready at edge E0: latch req_op/a/b into alu_op/alu_a/alu_b and req_tag into the tag register.
  - Load counter with LAT and go to WAIT.
  - alu_* hold their last values while idle.
- WAIT:
  - counter != 0: decrement by one each edge.
  - counter == 0: capture alu_result into rsp_result, set rsp_valid = 1, set rsp_err = 0, go to RESP.
  - Capture occurs at edge E0+LAT+1, so rsp_valid is first high after that edge.
  - Accept-to-rsp_valid latency is LAT+1 cycles; issue interval is at least LAT+3 cycles.
- RESP:
  - rsp_valid, rsp_result, rsp_tag and rsp_err are held stable until rsp_ready.
  - On rsp_valid & rsp_ready: clear rsp_valid and go to IDLE. A new request is accepted no earlier than the following edge.
- Backpressure: rsp_ready low holds RESP indefinitely. No request is accepted and alu_* stay stable.
- Arithmetic follows the ALU:
  - Add: a+b. Sub: b−a. Mul: a·b truncated to the low WIDTH bits. Div: b/a, unsigned.
  - The issuer performs no arithmetic; it only routes and captures.
- req_* values are sampled only on the accepting edge; changes at any other time are ignored.
- Reset asserted during WAIT or RESP returns to IDLE immediately. The next request after rst_n deassertion behaves normally.

Optional Feature:
- Macro: ALU_DIVZERO_CHECK_EN.
- Defined:
  - An accepted request with op=11 and req_a==0 is not issued; alu_* are not updated.
  - FSM goes IDLE→RESP directly. On the next edge: rsp_valid=1, rsp_result = all ones, rsp_err=1, rsp_tag = req_tag.
  - All other requests set rsp_err=0.
- Undefined: divide-by-zero is issued to the ALU like any other request. rsp_err is tied to 0 and no compare logic is built.

Decomposition:
- Package alu_pkg holds:
  - Opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11.
  - The state encoding IDLE/WAIT/RESP.
  - LAT_MAX=15.
- No sub-module: the FSM, latency counter and response register are one module. The ALU is instantiated by the parent, not inside alu_issuer.

Test Plan:
- LAT=1, Add a=5, b=7, tag=3 → alu_op=00, alu_a=5, alu_b=7 after accept edge; rsp_valid after 2 edges; rsp_result=12, rsp_tag=3, rsp_err=0.
- LAT=3, Sub a=4, b=10, then Div a=3, b=100 back-to-back with rsp_ready=1 → results 6 then 33; req_ready low from accept until the RESP handshake; second accept no earlier than LAT+3 edges after the first.
- Mul a=0x10000, b=0x10000 (WIDTH=32) → rsp_result=0; rsp_ready held low 10 cycles → rsp_valid and rsp_result stable, req_ready=0 throughout.
- ALU_DIVZERO_CHECK_EN defined, Div a=0, b=9, tag=7 → rsp_valid one edge after accept; rsp_result=0xFFFFFFFF, rsp_err=1, tag=7; alu_* unchanged. Undefined → request is issued and rsp_err=0.
- rst_n pulsed low during WAIT → rsp_valid=0, alu_*=0, req_ready=1 immediately; next request Add 1+1 returns 2.
- req_a/req_b toggled while in WAIT → alu_* and rsp_result reflect only the values sampled at the accept edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer.
// Contents: opcode constants, FSM state encoding, latency limit and counter width.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Largest supported ALU latency; sizes the wait counter.
    localparam int unsigned LAT_MAX = 15;
    localparam int unsigned CNT_W   = $clog2(LAT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_issuer_if.sv
// Handshake bundle around the ALU issuer.
// Signals: request channel (req_*), ALU command/result (alu_*), response channel (rsp_*).
// Modports: master = the issuer itself; slave = its environment (sequencer + ALU).
interface alu_issuer_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
) ();

    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [TAG_W-1:0] req_tag;

    logic [1:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;

    modport master (
        input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready, alu_result,
        output req_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_result, rsp_tag, rsp_err
    );

    modport slave (
        output req_valid, req_op, req_a, req_b, req_tag, rsp_ready, alu_result,
        input  req_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_result, rsp_tag, rsp_err
    );

endinterface

// File: rtl/alu_issuer.sv
// Single-outstanding command issuer for the registered four-op ALU.
// Accepts a request, drives the ALU operands, waits LAT edges, captures the result
// and returns it with the request tag.
// Ports: clk, rst_n (async active-low), bus (alu_issuer_if.master).
// Optional: ALU_DIVZERO_CHECK_EN short-circuits Div with a zero divisor to an
// all-ones error response without touching the ALU.
module alu_issuer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LAT   = 1,
    parameter int unsigned TAG_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_issuer_if.master bus
);

    state_e             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [1:0]         r_alu_op, w_alu_op_nxt;
    logic [WIDTH-1:0]   r_alu_a, w_alu_a_nxt;
    logic [WIDTH-1:0]   r_alu_b, w_alu_b_nxt;
    logic               r_rsp_valid, w_rsp_valid_nxt;
    logic [WIDTH-1:0]   r_rsp_result, w_rsp_result_nxt;
    logic [TAG_W-1:0]   r_rsp_tag, w_rsp_tag_nxt;
    logic               w_req_ready;
    logic               w_div_zero;

`ifdef ALU_DIVZERO_CHECK_EN
    logic               r_rsp_err, w_rsp_err_nxt;

    assign w_div_zero = (bus.req_op == OP_DIV) && (bus.req_a == '0);
`else
    assign w_div_zero = 1'b0;
`endif

    assign w_req_ready = (r_state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_alu_op_nxt     = r_alu_op;
        w_alu_a_nxt      = r_alu_a;
        w_alu_b_nxt      = r_alu_b;
        w_rsp_valid_nxt  = r_rsp_valid;
        w_rsp_result_nxt = r_rsp_result;
        w_rsp_tag_nxt    = r_rsp_tag;
`ifdef ALU_DIVZERO_CHECK_EN
        w_rsp_err_nxt    = r_rsp_err;
`endif
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_rsp_tag_nxt = bus.req_tag;
                    if (w_div_zero) begin
                        // Never issued; RESP fills in the error response next edge.
                        w_state_nxt = RESP;
                    end else begin
                        w_alu_op_nxt = bus.req_op;
                        w_alu_a_nxt  = bus.req_a;
                        w_alu_b_nxt  = bus.req_b;
                        w_cnt_nxt    = CNT_W'(LAT);
                        w_state_nxt  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_rsp_result_nxt = bus.alu_result;
                    w_rsp_valid_nxt  = 1'b1;
`ifdef ALU_DIVZERO_CHECK_EN
                    w_rsp_err_nxt    = 1'b0;
`endif
                    w_state_nxt      = RESP;
                end
            end
            RESP: begin
                if (r_rsp_valid) begin
                    if (bus.rsp_ready) begin
                        w_rsp_valid_nxt = 1'b0;
                        w_state_nxt     = IDLE;
                    end
                end
`ifdef ALU_DIVZERO_CHECK_EN
                else begin
                    // Entered directly from IDLE on a zero divisor.
                    w_rsp_valid_nxt  = 1'b1;
                    w_rsp_result_nxt = '1;
                    w_rsp_err_nxt    = 1'b1;
                end
`endif
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_alu_op     <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_tag    <= '0;
`ifdef ALU_DIVZERO_CHECK_EN
            r_rsp_err    <= 1'b0;
`endif
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_alu_op     <= w_alu_op_nxt;
            r_alu_a      <= w_alu_a_nxt;
            r_alu_b      <= w_alu_b_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_result <= w_rsp_result_nxt;
            r_rsp_tag    <= w_rsp_tag_nxt;
`ifdef ALU_DIVZERO_CHECK_EN
            r_rsp_err    <= w_rsp_err_nxt;
`endif
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.alu_op     = r_alu_op;
    assign bus.alu_a      = r_alu_a;
    assign bus.alu_b      = r_alu_b;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_tag    = r_rsp_tag;
`ifdef ALU_DIVZERO_CHECK_EN
    assign bus.rsp_err    = r_rsp_err;
`else
    assign bus.rsp_err    = 1'b0;
`endif

endmodule
